// File: rtl/approx_mul_err_monitor.sv
// Error-distance monitor for an approximate 8x8 multiplier: 4-stage pipeline, windowed statistics.
// Optional sum of squared error distances enabled with APPROX_MUL_ERR_SQ_EN.
module approx_mul_err_monitor #(
    parameter int WINDOW_LOG2 = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               x,
    input  logic [7:0]               y,
    input  logic [15:0]              z,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15+WINDOW_LOG2:0]  sum_ed,
    output logic [15:0]              max_ed,
    output logic [WINDOW_LOG2:0]     err_cnt
`ifdef APPROX_MUL_ERR_SQ_EN
    ,
    output logic [31+WINDOW_LOG2:0]  sum_sq_ed
`endif
);

    typedef enum logic [1:0] {ACCUM, DRAIN, REPORT} state_e;

    localparam logic [WINDOW_LOG2:0] WIN_CNT = {1'b1, {WINDOW_LOG2{1'b0}}};

    state_e                    state_q, state_d;
    logic [WINDOW_LOG2:0]      cnt_q, cnt_d;
    logic                      s1_v_q, s1_v_d;
    logic [7:0]                x1_q, x1_d;
    logic [7:0]                y1_q, y1_d;
    logic [15:0]               z1_q, z1_d;
    logic                      s2_v_q, s2_v_d;
    logic [15:0]               prod2_q, prod2_d;
    logic [15:0]               z2_q, z2_d;
    logic                      s3_v_q, s3_v_d;
    logic [15:0]               ed3_q, ed3_d;
    logic [15+WINDOW_LOG2:0]   sum_q, sum_d;
    logic [15:0]               max_q, max_d;
    logic [WINDOW_LOG2:0]      err_q, err_d;
    logic                      accept;
`ifdef APPROX_MUL_ERR_SQ_EN
    logic [31+WINDOW_LOG2:0]   sq_q, sq_d;
    logic [31:0]               ed_sq;
`endif

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == REPORT);
    assign accept    = in_valid && in_ready && !clear;
    assign sum_ed    = sum_q;
    assign max_ed    = max_q;
    assign err_cnt   = err_q;
`ifdef APPROX_MUL_ERR_SQ_EN
    assign sum_sq_ed = sq_q;
    assign ed_sq     = {16'b0, ed3_q} * {16'b0, ed3_q};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s1_v_d  = accept;
        x1_d    = x;
        y1_d    = y;
        z1_d    = z;
        s2_v_d  = s1_v_q;
        prod2_d = {8'b0, x1_q} * {8'b0, y1_q};
        z2_d    = z1_q;
        s3_v_d  = s2_v_q;
        ed3_d   = (prod2_q >= z2_q) ? (prod2_q - z2_q) : (z2_q - prod2_q);
        sum_d   = sum_q;
        max_d   = max_q;
        err_d   = err_q;
`ifdef APPROX_MUL_ERR_SQ_EN
        sq_d    = sq_q;
`endif

        if (s3_v_q) begin
            sum_d = sum_q + (16+WINDOW_LOG2)'(ed3_q);
            if (ed3_q > max_q) max_d = ed3_q;
            if (ed3_q != 16'd0) err_d = err_q + (WINDOW_LOG2+1)'(1);
`ifdef APPROX_MUL_ERR_SQ_EN
            sq_d = sq_q + (32+WINDOW_LOG2)'(ed_sq);
`endif
        end

        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_q + (WINDOW_LOG2+1)'(1);
                    if (cnt_d == WIN_CNT) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Nothing new enters while draining, so a lone stage-3 sample is the last one
                if (s3_v_q && !s2_v_q && !s1_v_q) state_d = REPORT;
            end
            REPORT: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                    sum_d   = '0;
                    max_d   = '0;
                    err_d   = '0;
`ifdef APPROX_MUL_ERR_SQ_EN
                    sq_d    = '0;
`endif
                end
            end
            default: state_d = ACCUM;
        endcase

        if (clear) begin
            state_d = ACCUM;
            cnt_d   = '0;
            s1_v_d  = 1'b0;
            s2_v_d  = 1'b0;
            s3_v_d  = 1'b0;
            sum_d   = '0;
            max_d   = '0;
            err_d   = '0;
`ifdef APPROX_MUL_ERR_SQ_EN
            sq_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            s1_v_q  <= 1'b0;
            x1_q    <= '0;
            y1_q    <= '0;
            z1_q    <= '0;
            s2_v_q  <= 1'b0;
            prod2_q <= '0;
            z2_q    <= '0;
            s3_v_q  <= 1'b0;
            ed3_q   <= '0;
            sum_q   <= '0;
            max_q   <= '0;
            err_q   <= '0;
`ifdef APPROX_MUL_ERR_SQ_EN
            sq_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s1_v_q  <= s1_v_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            z1_q    <= z1_d;
            s2_v_q  <= s2_v_d;
            prod2_q <= prod2_d;
            z2_q    <= z2_d;
            s3_v_q  <= s3_v_d;
            ed3_q   <= ed3_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            err_q   <= err_d;
`ifdef APPROX_MUL_ERR_SQ_EN
            sq_q    <= sq_d;
`endif
        end
    end

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Bench for approx_mul_err_monitor at WINDOW_LOG2=2: directed table, random windows, corner sequences.
module tb_approx_mul_err_monitor;

    localparam int W = 2;
    localparam int N = 1 << W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       x = '0;
    logic [7:0]       y = '0;
    logic [15:0]      z = '0;
    logic             clear = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15+W:0]    sum_ed;
    logic [15:0]      max_ed;
    logic [W:0]       err_cnt;
`ifdef APPROX_MUL_ERR_SQ_EN
    logic [31+W:0]    sum_sq_ed;
`endif

    approx_mul_err_monitor #(.WINDOW_LOG2(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .z         (z),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_ed    (sum_ed),
        .max_ed    (max_ed),
        .err_cnt   (err_cnt)
`ifdef APPROX_MUL_ERR_SQ_EN
        ,
        .sum_sq_ed (sum_sq_ed)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] z;
    } smp_t;

    typedef struct {
        smp_t   s[4];
        longint sum;
        int     mx;
        int     cnt;
        longint sq;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    smp_t win[$];
    vec_t tbl[3];

    function automatic smp_t mk(input int a, input int b, input int c);
        smp_t s;
        s.x = 8'(a);
        s.y = 8'(b);
        s.z = 16'(c);
        return s;
    endfunction

    // Reference: statistics straight from the definition of error distance
    task automatic model(output longint sum, output int mx,
                         output int cnt, output longint sq);
        sum = 0; mx = 0; cnt = 0; sq = 0;
        foreach (win[i]) begin
            int d;
            d = int'(win[i].x) * int'(win[i].y) - int'(win[i].z);
            if (d < 0) d = -d;
            sum += d;
            sq  += longint'(d) * longint'(d);
            if (d > mx) mx = d;
            if (d != 0) cnt++;
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input smp_t s);
        int n;
        in_valid = 1'b1;
        x = s.x;
        y = s.y;
        z = s.z;
        n = 0;
        while (!in_ready && n < 20) begin
            tick;
            n++;
        end
        if (n == 20) chk("in_ready_timeout", 0, 1);
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_report(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick;
            lat++;
        end
    endtask

    task automatic run_window(input string nm, input longint esum, input int emax,
                              input int ecnt, input longint esq,
                              input int maxgap, input int rdelay);
        int lat;
        foreach (win[i]) begin
            send_sample(win[i]);
            if (i < win.size() - 1)
                repeat ($urandom_range(0, maxgap)) tick;
        end
        wait_report(lat);
        chk({nm, "_latency"}, lat, 4);
        chk({nm, "_sum"}, sum_ed, esum);
        chk({nm, "_max"}, max_ed, emax);
        chk({nm, "_cnt"}, err_cnt, ecnt);
`ifdef APPROX_MUL_ERR_SQ_EN
        chk({nm, "_sq"}, sum_sq_ed, esq);
`else
        if (esq < 0) chk({nm, "_sq_neg"}, esq, 0);
`endif
        repeat (rdelay) begin
            tick;
            chk({nm, "_hold_valid"}, out_valid, 1);
            chk({nm, "_hold_sum"}, sum_ed, esum);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk({nm, "_post_ready"}, in_ready, 1);
        chk({nm, "_post_valid"}, out_valid, 0);
        chk({nm, "_post_sum"}, sum_ed, 0);
        chk({nm, "_post_cnt"}, err_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        longint esum, esq;
        int emax, ecnt, lat;

        tbl[0].s[0] = mk(3, 5, 14);
        tbl[0].s[1] = mk(10, 10, 102);
        tbl[0].s[2] = mk(255, 255, 65022);
        tbl[0].s[3] = mk(7, 8, 60);
        tbl[0].sum = 10; tbl[0].mx = 4; tbl[0].cnt = 4; tbl[0].sq = 30;
        for (int i = 0; i < 4; i++) tbl[1].s[i] = mk(255, 255, 0);
        tbl[1].sum = 260100; tbl[1].mx = 65025; tbl[1].cnt = 4;
        tbl[1].sq = 4 * 64 'd4228250625;
        for (int i = 0; i < 4; i++) tbl[2].s[i] = mk(200, 100, 20000);
        tbl[2].sum = 0; tbl[2].mx = 0; tbl[2].cnt = 0; tbl[2].sq = 0;

        repeat (2) tick;
        rst = 1'b0;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sum", sum_ed, 0);
        chk("reset_max", max_ed, 0);
        chk("reset_cnt", err_cnt, 0);

        for (int t = 0; t < 3; t++) begin
            win.delete();
            for (int i = 0; i < N; i++) win.push_back(tbl[t].s[i]);
            run_window($sformatf("table%0d", t), tbl[t].sum, tbl[t].mx,
                       tbl[t].cnt, tbl[t].sq, 0, 2);
        end

        for (int w = 0; w < 25; w++) begin
            win.delete();
            for (int i = 0; i < N; i++) begin
                int a, b, p, c;
                a = $urandom_range(0, 255);
                b = $urandom_range(0, 255);
                p = a * b;
                case ($urandom_range(0, 3))
                    0: c = p;
                    1: c = p + $urandom_range(0, 9);
                    2: c = p - $urandom_range(0, 9);
                    default: c = $urandom_range(0, 65535);
                endcase
                if (c < 0) c = 0;
                if (c > 65535) c = 65535;
                win.push_back(mk(a, b, c));
            end
            model(esum, emax, ecnt, esq);
            run_window($sformatf("rand%0d", w), esum, emax, ecnt, esq,
                       2, $urandom_range(0, 3));
        end

        // Stalled report with a sample waiting
        win.delete();
        for (int i = 0; i < N; i++) win.push_back(tbl[0].s[i]);
        foreach (win[i]) send_sample(win[i]);
        wait_report(lat);
        chk("stall_latency", lat, 4);
        in_valid = 1'b1;
        x = 8'd2; y = 8'd3; z = 16'd7;
        repeat (6) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_sum", sum_ed, 10);
            chk("stall_cnt", err_cnt, 4);
            chk("stall_max", max_ed, 4);
            tick;
        end
        out_ready = 1'b1;
        chk("stall_hs_in_ready", in_ready, 0);
        tick;
        out_ready = 1'b0;
        chk("stall_after_ready", in_ready, 1);
        chk("stall_after_sum", sum_ed, 0);
        tick;
        in_valid = 1'b0;
        win.delete();
        for (int i = 0; i < N - 1; i++) win.push_back(mk(4, 4, 16));
        run_window("stall_next", 1, 1, 1, 1, 0, 0);

        // Clear mid-window, offered sample discarded
        send_sample(tbl[1].s[0]);
        send_sample(tbl[1].s[1]);
        clear = 1'b1;
        in_valid = 1'b1;
        x = 8'd255; y = 8'd255; z = 16'd0;
        tick;
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clear_out_valid", out_valid, 0);
        chk("clear_sum", sum_ed, 0);
        chk("clear_in_ready", in_ready, 1);
        repeat (4) tick;
        chk("clear_flush_sum", sum_ed, 0);
        chk("clear_flush_cnt", err_cnt, 0);
        win.delete();
        win.push_back(mk(2, 3, 7));
        win.push_back(mk(3, 3, 8));
        win.push_back(mk(1, 1, 0));
        win.push_back(mk(4, 4, 15));
        run_window("clear_win", 4, 1, 4, 4, 1, 1);

        // Clear coincident with the report handshake
        win.delete();
        for (int i = 0; i < N; i++) win.push_back(tbl[1].s[i]);
        foreach (win[i]) send_sample(win[i]);
        wait_report(lat);
        chk("clrhs_latency", lat, 4);
        clear = 1'b1;
        out_ready = 1'b1;
        tick;
        clear = 1'b0;
        out_ready = 1'b0;
        chk("clrhs_out_valid", out_valid, 0);
        chk("clrhs_sum", sum_ed, 0);
        chk("clrhs_max", max_ed, 0);
        chk("clrhs_cnt", err_cnt, 0);
        chk("clrhs_in_ready", in_ready, 1);

        // Reset while draining
        foreach (win[i]) send_sample(win[i]);
        chk("drain_in_ready", in_ready, 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rstdrain_in_ready", in_ready, 1);
        chk("rstdrain_out_valid", out_valid, 0);
        chk("rstdrain_sum", sum_ed, 0);
        chk("rstdrain_max", max_ed, 0);
        chk("rstdrain_cnt", err_cnt, 0);
        repeat (5) tick;
        chk("rstdrain_late_valid", out_valid, 0);
        chk("rstdrain_late_sum", sum_ed, 0);

        win.delete();
        for (int i = 0; i < N; i++) win.push_back(tbl[0].s[i]);
        run_window("after_rst", 10, 4, 4, 30, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
